// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants, RGB565 field layout and framebuffer address type.
package vga_pkg;

  // 640x480 @ 60 Hz raster, 25 MHz pixel clock derived from a 100 MHz system clock
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_CLK_DIV  = 4;
  localparam int unsigned VGA_RD_LAT   = 2;

  // Framebuffer word address and pixel word widths
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned COL_W  = 4;

  // Top bits of each RGB565 field; the 4-bit output takes the upper nibble of each
  localparam int unsigned RGB565_R_MSB = 15;
  localparam int unsigned RGB565_G_MSB = 10;
  localparam int unsigned RGB565_B_MSB = 4;

  typedef logic [ADDR_W-1:0] fb_addr_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel strobe divider, raster counters and region decode for the current raster position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic rstn,
  output logic pix_en_c,
  output logic active_c,
  output logic hs_n_c,
  output logic vs_n_c,
  output logic vblank_c,
  output logic wrap_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  logic [DW-1:0] div_q;
  logic [HW-1:0] hcnt_q;
  logic [VW-1:0] vcnt_q;
  logic          h_last_c;
  logic          v_last_c;

  assign pix_en_c = (div_q == DW'(CLK_DIV - 1));
  assign h_last_c = (hcnt_q == HW'(H_TOTAL - 1));
  assign v_last_c = (vcnt_q == VW'(V_TOTAL - 1));

  // Free-running clk divider producing one pixel strobe every CLK_DIV clks
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
    end else if (pix_en_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Raster position; vcnt steps when hcnt wraps, both wrap together at the frame end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (pix_en_c) begin
      if (h_last_c) begin
        hcnt_q <= '0;
        vcnt_q <= v_last_c ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_q <= hcnt_q + HW'(1);
      end
    end
  end

  assign active_c = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
  assign hs_n_c   = !((hcnt_q >= HW'(HS_BEG)) && (hcnt_q < HW'(HS_END)));
  assign vs_n_c   = !((vcnt_q >= VW'(VS_BEG)) && (vcnt_q < VW'(VS_END)));
  assign vblank_c = (vcnt_q >= VW'(V_ACTIVE));
  assign wrap_c   = h_last_c && v_last_c;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: base latch, linear read address generation, and RGB565->RGB444 VGA output.
module fb_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned RD_LAT   = VGA_RD_LAT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] fb_base,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [PIX_W-1:0]  fb_data,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic [COL_W-1:0]  vga_r,
  output logic [COL_W-1:0]  vga_g,
  output logic [COL_W-1:0]  vga_b,
  output logic              vblank,
  output logic              frame_start
);

  // Read data is sampled one pixel period after the address, so it must settle within it
  if (RD_LAT >= CLK_DIV) begin : g_lat_chk
    $error("fb_scanout: RD_LAT must be less than CLK_DIV");
  end

  logic     pix_en_c, active_c, hs_n_c, vs_n_c, vblank_c, wrap_c;
  fb_addr_t base_lat;
  fb_addr_t offset;
  logic     act_d, hs_d, vs_d, vb_d;
  logic [3:0] unused_lsbs;

  // RGB565 bits dropped by the 4-bit DAC
  assign unused_lsbs = {fb_data[11], fb_data[6:5], fb_data[0]};

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk      (clk),
    .rstn     (rstn),
    .pix_en_c (pix_en_c),
    .active_c (active_c),
    .hs_n_c   (hs_n_c),
    .vs_n_c   (vs_n_c),
    .vblank_c (vblank_c),
    .wrap_c   (wrap_c)
  );

  // Base latch and running pixel offset; the sum replaces a line*width multiply
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_lat <= '0;
      offset   <= '0;
      fb_addr  <= '0;
    end else if (pix_en_c) begin
      if (active_c) begin
        fb_addr <= base_lat + offset;
      end
      if (wrap_c) begin
        base_lat <= fb_base;
        offset   <= '0;
      end else if (active_c) begin
        offset <= offset + fb_addr_t'(1);
      end
    end
  end

  // Delay the region decode one pixel so syncs line up with the returning read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_d <= 1'b0;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      vb_d  <= 1'b0;
    end else if (pix_en_c) begin
      act_d <= active_c;
      hs_d  <= hs_n_c;
      vs_d  <= vs_n_c;
      vb_d  <= vblank_c;
    end
  end

  // Colour and sync output stage, blanked outside the active area
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vblank <= 1'b0;
    end else if (pix_en_c) begin
      vga_r  <= act_d ? fb_data[RGB565_R_MSB -: COL_W] : '0;
      vga_g  <= act_d ? fb_data[RGB565_G_MSB -: COL_W] : '0;
      vga_b  <= act_d ? fb_data[RGB565_B_MSB -: COL_W] : '0;
      vga_hs <= hs_d;
      vga_vs <= vs_d;
      vblank <= vb_d;
    end
  end

  // One-clk pulse on the strobe that wraps the raster back to (0,0)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en_c && wrap_c;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scaled-raster bench for fb_scanout with a pixel-count reference model and RD_LAT=2 memory.
module tb_fb_scanout;

  localparam int unsigned HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int unsigned VA = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int unsigned CD = 4;
  localparam int unsigned HT = HA + HFP + HS + HBP;   // 25
  localparam int unsigned VT = VA + VFP + VS + VBP;   // 15
  localparam int unsigned FR = HT * VT;               // 375 pixels per frame

  logic        clk = 1'b0;
  logic        rstn;
  logic [18:0] fb_base;
  logic [18:0] fb_addr;
  logic [15:0] fb_data;
  logic        vga_hs, vga_vs, vblank, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(CD), .RD_LAT(2)
  ) dut (
    .clk(clk), .rstn(rstn), .fb_base(fb_base), .fb_addr(fb_addr), .fb_data(fb_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer read port with two clks of latency
  logic [15:0] mem [0:(1<<19)-1];
  logic [15:0] rd1;
  always @(posedge clk) begin
    rd1     <= mem[fb_addr];
    fb_data <= rd1;
  end

  int n_pass = 0;
  int n_total = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: clks since reset release, pixel strobes seen, base of each frame
  int unsigned m_n = 0;
  int unsigned m_p = 0;
  int unsigned m_base [0:63];

  always @(posedge clk) begin
    int unsigned nn, pp;
    if (!rstn) begin
      m_n <= 0;
      m_p <= 0;
      for (int i = 0; i < 64; i++) m_base[i] <= 0;
    end else begin
      nn = m_n + 1;
      pp = m_p + ((nn % CD == 0) ? 1 : 0);
      if ((nn % CD == 0) && (pp % FR == 0) && (pp / FR < 64)) m_base[pp / FR] <= 32'(fb_base);
      m_n <= nn;
      m_p <= pp;
    end
  end

  // Address of the most recent active pixel issued after p strobes
  function automatic logic [18:0] exp_addr(input int unsigned p);
    int unsigned q, f, r, v, h;
    if (p == 0) return '0;
    q = p - 1; f = q / FR; r = q % FR; v = r / HT; h = r % HT;
    if (v >= VA) begin v = VA - 1; h = HA - 1; end
    else if (h >= HA) h = HA - 1;
    return 19'(m_base[f] + v * HA + h);
  endfunction

  // {hs_n, vs_n, vblank, r, g, b} of the pixel being displayed after p strobes
  function automatic logic [14:0] exp_out(input int unsigned p);
    int unsigned q, f, r, v, h;
    logic [15:0] d;
    logic act;
    if (p < 2) return {3'b110, 12'h000};
    q = p - 2; f = q / FR; r = q % FR; v = r / HT; h = r % HT;
    act = (v < VA) && (h < HA);
    d = mem[19'(m_base[f] + v * HA + h)];
    return {!((h >= HA + HFP) && (h < HA + HFP + HS)),
            !((v >= VA + VFP) && (v < VA + VFP + VS)),
            (v >= VA),
            act ? {d[15:12], d[10:7], d[4:1]} : 12'h000};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [14:0] eo;
    if (cmp_en) begin
      eo = exp_out(m_p);
      check("fb_addr", 32'(fb_addr), 32'(exp_addr(m_p)));
      check("vga_hs", 32'(vga_hs), 32'(eo[14]));
      check("vga_vs", 32'(vga_vs), 32'(eo[13]));
      check("vblank", 32'(vblank), 32'(eo[12]));
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(eo[11:0]));
      check("frame_start", 32'(frame_start),
            32'((m_n != 0) && (m_n % CD == 0) && (m_p != 0) && (m_p % FR == 0)));
    end
  end

  // Sync and frame period measurements in clks
  int cyc = 0, hs_fall = -1, line_per = -1, hs_low = -1;
  int vs_fall = -1, vs_low = -1, fs_t = -1, frame_per = -1, fs_count = 0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  always @(negedge clk) begin
    if (!rstn) begin
      hs_fall = -1; line_per = -1; hs_low = -1; vs_fall = -1; vs_low = -1;
      fs_t = -1; frame_per = -1; fs_count = 0; hs_prev = 1'b1; vs_prev = 1'b1;
    end else begin
      cyc++;
      if (hs_prev && !vga_hs) begin
        if (hs_fall >= 0) line_per = cyc - hs_fall;
        hs_fall = cyc;
      end
      if (!hs_prev && vga_hs && hs_fall >= 0) hs_low = cyc - hs_fall;
      if (vs_prev && !vga_vs) vs_fall = cyc;
      if (!vs_prev && vga_vs && vs_fall >= 0) vs_low = cyc - vs_fall;
      if (frame_start) begin
        if (fs_t >= 0) frame_per = cyc - fs_t;
        fs_t = cyc;
        fs_count++;
      end
      hs_prev = vga_hs;
      vs_prev = vga_vs;
    end
  end

  task automatic wait_pix(input int unsigned k);
    int t = 0;
    while (m_p < k && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (m_p < k) check("wait_pix_timeout", 32'(m_p), 32'(k));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fb_addr"}, 32'(fb_addr), 32'h0);
    check({tag, "_syncs"}, 32'({vga_hs, vga_vs}), 32'h3);
    check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'h0);
    check({tag, "_vblank"}, 32'(vblank), 32'h0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'h0);
  endtask

  initial begin
    logic [18:0] rb;
    rstn = 1'b1;
    fb_base = '0;
    for (int i = 0; i < (1 << 19); i++) mem[i] = 16'($urandom);
    mem[0] = 16'hF800;
    mem[1] = 16'h07E0;
    mem[2] = 16'hFFFF;
    for (int v = 0; v < int'(VA); v++) mem[v * HA + HA - 1] = 16'hFFFF;

    #2 rstn = 1'b0;
    cmp_en = 1'b1;
    #1 check_reset_vals("por");
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;

    // First frame from base 0, colour mapping and blanking
    wait_pix(1);  check("addr_p0", 32'(fb_addr), 32'd0);
    wait_pix(2);  check("addr_p1", 32'(fb_addr), 32'd1);
                  check("rgb_F800", 32'({vga_r, vga_g, vga_b}), 32'hF00);
    wait_pix(3);  check("addr_p2", 32'(fb_addr), 32'd2);
                  check("rgb_07E0", 32'({vga_r, vga_g, vga_b}), 32'h0F0);
    wait_pix(4);  check("rgb_FFFF", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    wait_pix(16); check("addr_line0_last", 32'(fb_addr), 32'd15);
    wait_pix(17); check("rgb_line0_last", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    wait_pix(18); check("rgb_blank_ff", 32'({vga_r, vga_g, vga_b}), 32'h000);
    wait_pix(26); check("addr_line1_first", 32'(fb_addr), 32'd16);

    // Base change mid-frame must not disturb the current frame
    wait_pix(100); fb_base = 19'h4B000;
    wait_pix(150); check("addr_hold_old_base", 32'(fb_addr), 32'd95);
    wait_pix(191); check("addr_frame_last", 32'(fb_addr), 32'd127);
    wait_pix(FR + 1); check("addr_new_base", 32'(fb_addr), 32'h4B000);

    // Address wraps modulo 2^19
    wait_pix(FR + 50); fb_base = 19'h7FFFF;
    wait_pix(2 * FR + 1); check("addr_wrap0", 32'(fb_addr), 32'h7FFFF);
    wait_pix(2 * FR + 2); check("addr_wrap1", 32'(fb_addr), 32'h00000);

    wait_pix(2 * FR + 5);
    #1;
    check("line_period_clks", 32'(line_per), 32'(HT * CD));
    check("hs_low_clks", 32'(hs_low), 32'(HS * CD));
    check("vs_low_clks", 32'(vs_low), 32'(VS * HT * CD));
    check("frame_period_clks", 32'(frame_per), 32'(FR * CD));
    check("frame_start_count", 32'(fs_count), 32'd2);

    // Random base updates across frames 2 and 3
    for (int i = 0; i < 4; i++) begin
      wait_pix(2 * FR + 10 + i * 80 + $urandom_range(0, 60));
      fb_base = 19'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      wait_pix(3 * FR + 10 + i * 30 + $urandom_range(0, 20));
      fb_base = 19'($urandom);
    end

    // Asynchronous reset in the middle of line 5
    wait_pix(3 * FR + 5 * HT + $urandom_range(0, HT - 1));
    #1 rstn = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    wait_pix(1); check("addr_after_rst0", 32'(fb_addr), 32'd0);
    wait_pix(2); check("addr_after_rst1", 32'(fb_addr), 32'd1);
    rb = 19'($urandom);
    fb_base = rb;
    wait_pix(FR + 1); check("addr_rand_base0", 32'(fb_addr), 32'(rb));
    wait_pix(FR + 2); check("addr_rand_base1", 32'(fb_addr), 32'(19'(rb + 19'd1)));
    wait_pix(FR + 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Framebuffer reader and VGA timing generator: the consuming end of the framebuffer written by the tile/map renderers. It walks the 640x480 raster, issues one read per active pixel to the framebuffer's second (read) port, converts RGB565 to RGB444 and drives the VGA sync and colour pins. It also gives the renderers a latched frame base address, so they can double-buffer, and vblank/frame-start indications.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width in lines
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz)
- RD_LAT, 2, framebuffer read latency in clk cycles; must be < CLK_DIV

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- fb_base  in  19  framebuffer base word address for the next frame
- fb_addr  out  19  framebuffer read address (registered)
- fb_data  in  16  read data, RGB565, valid RD_LAT clks after fb_addr changes
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_r / vga_g / vga_b  out  4 each  colour, zero outside the active area
- vblank  out  1  high while the displayed line is >= V_ACTIVE
- frame_start  out  1  one-clk pulse at each raster wrap to (0,0)

## Operation

- pix_en: one-clk strobe every CLK_DIV clks, from a free-running counter. All raster state advances only on pix_en.
- Counters:
  - hcnt runs 0..H_TOTAL-1 (800).
  - vcnt runs 0..V_TOTAL-1 (525) and increments when hcnt wraps.
  - Both wrap to 0 together at (799,524).
- Region decode for the current (hcnt,vcnt):
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hs_n low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_n low for vcnt in the equivalent vertical window.
- Address generation, with no multiplier:
  - 19-bit offset register counts active pixels issued this frame.
  - On each active pix_en: fb_addr <= base_lat + offset, then offset increments.
  - Offset clears at frame wrap.
  - Maximum offset is 307199, so the 19-bit sum wraps modulo 2^19 with no saturation.
- Base latch:
  - base_lat loads fb_base on the pix_en at which counters wrap to (0,0).
  - fb_base changes mid-frame do not affect the current frame.
- Output stage, on each pix_en:
  - vga_r = fb_data[15:12], vga_g = fb_data[10:7], vga_b = fb_data[4:1] if the delayed active flag is set; else all zero.
  - vga_hs, vga_vs and vblank are loaded from the delayed decode of the same pixel.

## Timing

- Reset values:
  - hcnt = vcnt = 0, offset = 0, base_lat = 0, fb_addr = 0.
  - vga_hs = vga_vs = 1; rgb = 0; vblank = 0; frame_start = 0.
  - pix_en counter = 0.
- First frame after reset reads from base 0; fb_base is first sampled at the first wrap.
- Pipeline: the pixel at (h,v) has fb_addr issued on pix_en k and is displayed from pix_en k+1. Syncs carry the same one-pixel lag, so colour and sync stay aligned.
- fb_data is sampled exactly CLK_DIV clks after fb_addr updates, which is >= RD_LAT.
- fb_addr holds its last value outside the active area.
- frame_start is high for exactly one clk, the pix_en clk of the wrap, once per 420000 pixel periods.
- Reset asserted mid-frame: all outputs go to reset values asynchronously. Scan restarts at (0,0) after release, with the first pix_en CLK_DIV clks after release.

## Structure

- Package vga_pkg:
  - timing constants, plus derived H_TOTAL = 800 and V_TOTAL = 525
  - RGB565 field positions
  - 19-bit address type
- Sub-module vga_timing_gen: pix_en divider, hcnt/vcnt, and the active/hs/vs/vblank/frame-wrap decode.
- Top level: base latch, offset/address generation, read pipeline and colour output.

## Test plan

- Reset release, fb_base = 0:
  - first fb_addr values are 0, 1, 2 on successive pix_en.
  - the last active pixel of line 0 reads 639; line 1 starts at 640.
  - the last pixel of the frame reads 307199.
- Sync timing:
  - vga_hs is low for 96 pixel periods starting 656 pixels after line start (one-pixel lag included).
  - vga_vs is low for lines 490-491.
  - line period is 3200 clks; frame period is 1680000 clks.
- Base latch: set fb_base = 0x4B000 mid-frame.
  - the current frame continues from the old base.
  - the next frame's first fb_addr = 0x4B000.
  - frame_start pulses once, one clk wide.
- Colour mapping with a memory model of RD_LAT = 2:
  - word 0xF800 -> r = F, g = 0, b = 0.
  - word 0x07E0 -> r = 0, g = F, b = 0.
  - word 0xFFFF -> all F.
  - rgb = 0 in blanking even if fb_data = 0xFFFF.
- Wrap: fb_base = 0x7FFFF -> second pixel reads address 0x00000 (modulo 2^19).
- Reset mid-frame at line 200: outputs go to reset values immediately; after release the raster restarts at (0,0) with fb_addr = 0.
